// File: rtl/counter_ctrl_4bit_if.sv
// Control/status bundle for the 4-bit interval controller.
// master drives strobes and configuration, slave returns count status.
interface counter_ctrl_4bit_if #(
    parameter int PRESCALE_W = 4
);
    logic                  start;
    logic                  pause;
    logic                  stop;
    logic                  mode;
    logic [3:0]            period;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            q;
    logic                  busy;
    logic                  tick;
    logic                  done;
    logic                  err;

    modport master (
        output start, pause, stop, mode, period, prescale,
        input  q, busy, tick, done, err
    );

    modport slave (
        input  start, pause, stop, mode, period, prescale,
        output q, busy, tick, done, err
    );
endinterface

// File: rtl/counter_ctrl_4bit.sv
// Programmable interval controller sequencing a 4-bit up-counter
// with prescaler, pause/stop control and one-shot/auto-reload modes.
module counter_ctrl_4bit #(
    parameter int PRESCALE_W = 4
) (
    input logic clk,
    input logic rst,
    counter_ctrl_4bit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [3:0]            q, q_n;
    logic [PRESCALE_W-1:0] pcnt, pcnt_n;
    logic [3:0]            period_l, period_l_n;
    logic [PRESCALE_W-1:0] prescale_l, prescale_l_n;
    logic                  mode_l, mode_l_n;
    logic                  busy, tick, tick_n;
    logic                  done, done_n;
    logic                  err, err_n;
    logic                  run_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            pcnt       <= '0;
            period_l   <= '0;
            prescale_l <= '0;
            mode_l     <= 1'b0;
            busy       <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            q          <= q_n;
            pcnt       <= pcnt_n;
            period_l   <= period_l_n;
            prescale_l <= prescale_l_n;
            mode_l     <= mode_l_n;
            busy       <= (state_n != IDLE);
            tick       <= tick_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        q_n          = q;
        pcnt_n       = pcnt;
        period_l_n   = period_l;
        prescale_l_n = prescale_l;
        mode_l_n     = mode_l;
        tick_n       = 1'b0;
        done_n       = 1'b0;
        err_n        = 1'b0;
        run_ok       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.period != 4'd0) begin
                        period_l_n   = bus.period;
                        prescale_l_n = bus.prescale;
                        mode_l_n     = bus.mode;
                        q_n          = '0;
                        pcnt_n       = '0;
                        state_n      = RUN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    q_n     = '0;
                    pcnt_n  = '0;
                    state_n = IDLE;
                end else if (bus.pause) begin
                    state_n = PAUSE;
                end else begin
                    run_ok = 1'b1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    q_n     = '0;
                    pcnt_n  = '0;
                    state_n = IDLE;
                end else if (!bus.pause) begin
                    // the release edge counts like a normal run edge
                    state_n = RUN;
                    run_ok  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (run_ok) begin
            if (pcnt == prescale_l) begin
                pcnt_n = '0;
                tick_n = 1'b1;
                if (q != period_l) begin
                    q_n = q + 4'd1;
                end else begin
                    q_n    = '0;
                    done_n = 1'b1;
                    if (!mode_l) begin
                        state_n = IDLE;
                    end else begin
                        period_l_n   = bus.period;
                        prescale_l_n = bus.prescale;
                        mode_l_n     = bus.mode;
                        if (bus.period == 4'd0) begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                        end
                    end
                end
            end else begin
                pcnt_n = pcnt + 1'b1;
            end
        end
    end

    assign bus.q    = q;
    assign bus.busy = busy;
    assign bus.tick = tick;
    assign bus.done = done;
    assign bus.err  = err;
endmodule

// File: tb/tb_counter_ctrl_4bit.sv
// Directed bench for counter_ctrl_4bit: one-shot, reload, pause,
// stop, rejected start and asynchronous reset scenarios.
module tb_counter_ctrl_4bit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    counter_ctrl_4bit_if #(.PRESCALE_W(4)) bus ();

    counter_ctrl_4bit #(.PRESCALE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.stop     = 1'b0;
        bus.mode     = 1'b0;
        bus.period   = 4'd0;
        bus.prescale = 4'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_q", bus.q, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;

        // one-shot, period 5, no prescale
        bus.period = 4'd5;
        bus.start  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("t1_busy_k", bus.busy, 1);
        chk("t1_q_k", bus.q, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            chk("t1_q", bus.q, i);
            chk("t1_tick", bus.tick, 1);
            chk("t1_done0", bus.done, 0);
        end
        cyc(1);
        chk("t1_q_term", bus.q, 0);
        chk("t1_done", bus.done, 1);
        chk("t1_tick_term", bus.tick, 1);
        chk("t1_busy_term", bus.busy, 0);
        cyc(1);
        chk("t1_done_pulse", bus.done, 0);
        chk("t1_tick_after", bus.tick, 0);

        // auto-reload, period 3, prescale 2, period changed mid-run
        bus.period   = 4'd3;
        bus.prescale = 4'd2;
        bus.mode     = 1'b1;
        bus.start    = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        chk("t2_q_k2", bus.q, 0);
        cyc(1);
        chk("t2_q_k3", bus.q, 1);
        cyc(8);
        chk("t2_done_k11", bus.done, 0);
        cyc(1);
        chk("t2_done_k12", bus.done, 1);
        chk("t2_busy_k12", bus.busy, 1);
        chk("t2_q_k12", bus.q, 0);
        bus.period = 4'd1;
        cyc(11);
        chk("t2_done_k23", bus.done, 0);
        cyc(1);
        chk("t2_done_k24", bus.done, 1);
        chk("t2_err_k24", bus.err, 0);
        cyc(5);
        chk("t2_done_k29", bus.done, 0);
        cyc(1);
        chk("t2_done_k30", bus.done, 1);
        chk("t2_busy_k30", bus.busy, 1);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        chk("t2_stop_busy", bus.busy, 0);
        chk("t2_stop_q", bus.q, 0);

        // pause for four cycles at q=2
        bus.period   = 4'd5;
        bus.prescale = 4'd0;
        bus.mode     = 1'b0;
        bus.start    = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        chk("t3_q_k2", bus.q, 2);
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t3_q_frozen", bus.q, 2);
            chk("t3_busy_pause", bus.busy, 1);
            chk("t3_tick_pause", bus.tick, 0);
        end
        bus.pause = 1'b0;
        cyc(1);
        chk("t3_q_k7", bus.q, 3);
        cyc(2);
        chk("t3_q_k9", bus.q, 5);
        chk("t3_done_k9", bus.done, 0);
        cyc(1);
        chk("t3_done_k10", bus.done, 1);
        chk("t3_busy_k10", bus.busy, 0);

        // start while busy ignored, stop on the terminal step
        bus.period = 4'd2;
        bus.start  = 1'b1;
        cyc(1);
        bus.period = 4'd0;
        cyc(1);
        chk("t4_q_k1", bus.q, 1);
        chk("t4_err_busy", bus.err, 0);
        cyc(1);
        chk("t4_q_k2", bus.q, 2);
        chk("t4_busy_k2", bus.busy, 1);
        chk("t4_err_k2", bus.err, 0);
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        chk("t4_done_stop", bus.done, 0);
        chk("t4_tick_stop", bus.tick, 0);
        chk("t4_q_stop", bus.q, 0);
        chk("t4_busy_stop", bus.busy, 0);

        // rejected start
        bus.period = 4'd0;
        bus.start  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("t5_err", bus.err, 1);
        chk("t5_busy", bus.busy, 0);
        chk("t5_q", bus.q, 0);
        chk("t5_done", bus.done, 0);
        cyc(1);
        chk("t5_err_pulse", bus.err, 0);

        // asynchronous reset while paused at q=3
        bus.period = 4'd5;
        bus.start  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(3);
        chk("t6_q_k3", bus.q, 3);
        bus.pause = 1'b1;
        cyc(1);
        chk("t6_q_paused", bus.q, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_q", bus.q, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_tick", bus.tick, 0);
        bus.pause = 1'b0;
        #1;
        rst        = 1'b0;
        bus.period = 4'd2;
        bus.start  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("t6_busy_k", bus.busy, 1);
        cyc(2);
        chk("t6_done_k2", bus.done, 0);
        cyc(1);
        chk("t6_done_k3", bus.done, 1);
        chk("t6_busy_k3", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
